// File: rtl/clk_gate_ctrl_pkg.sv
// Shared types and constants for the activity-driven clock-gate controller.
// Optional statistics outputs are enabled by the CLK_GATE_CTRL_STATS_EN macro.
package clk_gate_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_OFF  = 2'b01,
    ST_WAKE = 2'b10
  } state_t;

  localparam int unsigned GATED_CNT_W = 32;
  localparam int unsigned WAKE_CNT_W  = 16;

  // Bits needed to hold 0..n; never below 1 so an illegal n still elaborates.
  function automatic int unsigned cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/clk_gate_sat_cnt.sv
// Saturating up-counter with synchronous clear; holds at LIMIT instead of wrapping.
module clk_gate_sat_cnt #(
  parameter int unsigned       WIDTH = 4,
  parameter logic [WIDTH-1:0]  LIMIT = '1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count,
  output logic             o_at_limit
);

  logic [WIDTH-1:0] r_count;

  assign o_count    = r_count;
  assign o_at_limit = (r_count == LIMIT);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && !o_at_limit) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/clk_gate_ctrl.sv
// Clock-enable controller for a CE-gated global clock buffer: gates after idle, restores on demand.
// Define CLK_GATE_CTRL_STATS_EN to add the GATED_CYCLES / WAKE_COUNT statistics outputs.
module clk_gate_ctrl
  import clk_gate_ctrl_pkg::*;
#(
  parameter int IDLE_CYCLES    = 16,
  parameter int MIN_OFF_CYCLES = 4,
  parameter int WAKE_CYCLES    = 2,
  parameter int IS_CE_INVERTED = 0
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        BUSY,
  input  logic        FORCE_ON,
  output logic        CE,
  output logic        CLK_ACTIVE,
  output logic [1:0]  STATE
`ifdef CLK_GATE_CTRL_STATS_EN
  ,
  output logic [GATED_CNT_W-1:0] GATED_CYCLES,
  output logic [WAKE_CNT_W-1:0]  WAKE_COUNT
`endif
);

  if (IDLE_CYCLES < 1 || MIN_OFF_CYCLES < 1 || WAKE_CYCLES < 1 ||
      (IS_CE_INVERTED != 0 && IS_CE_INVERTED != 1)) begin : g_bad_params
    $fatal(1, "%m: illegal parameter (IDLE_CYCLES=%0d MIN_OFF_CYCLES=%0d WAKE_CYCLES=%0d IS_CE_INVERTED=%0d)",
           IDLE_CYCLES, MIN_OFF_CYCLES, WAKE_CYCLES, IS_CE_INVERTED);
  end

  localparam int unsigned IDLE_W = cnt_width(IDLE_CYCLES);
  localparam int unsigned OFF_W  = cnt_width(MIN_OFF_CYCLES);
  localparam int unsigned WAKE_W = cnt_width(WAKE_CYCLES);

  localparam logic [IDLE_W-1:0] IDLE_LIM = IDLE_W'(IDLE_CYCLES - 1);
  localparam logic [OFF_W-1:0]  OFF_LIM  = OFF_W'(MIN_OFF_CYCLES - 1);
  localparam logic [WAKE_W-1:0] WAKE_LIM = WAKE_W'(WAKE_CYCLES - 1);

  localparam logic CE_INV = (IS_CE_INVERTED == 1);
  localparam logic CE_ON  = 1'b1 ^ CE_INV;

  state_t r_state;
  state_t w_next_state;
  logic   r_ce;
  logic   r_clk_active;
  logic   r_wake_pend;

  logic w_wanted, w_idle;
  logic w_go_off, w_go_wake;
  logic w_idle_at_lim, w_off_at_lim, w_wake_at_lim;
  logic [IDLE_W-1:0] w_idle_cnt;
  logic [OFF_W-1:0]  w_off_cnt;
  logic [WAKE_W-1:0] w_wake_cnt;

  assign w_wanted = BUSY | FORCE_ON;
  assign w_idle   = ~w_wanted;

  assign w_go_off  = (r_state == ST_RUN) && w_idle && w_idle_at_lim;
  assign w_go_wake = (r_state == ST_OFF) && w_off_at_lim && (w_wanted || r_wake_pend);

  // idle_cnt is held at 0 outside RUN, so every return from WAKE starts a fresh idle window.
  clk_gate_sat_cnt #(.WIDTH(IDLE_W), .LIMIT(IDLE_LIM)) u_idle_cnt (
    .i_clk      (CLK),
    .i_rst_n    (RST_N),
    .i_clr      ((r_state != ST_RUN) || w_wanted || w_go_off),
    .i_inc      ((r_state == ST_RUN) && w_idle),
    .o_count    (w_idle_cnt),
    .o_at_limit (w_idle_at_lim)
  );

  clk_gate_sat_cnt #(.WIDTH(OFF_W), .LIMIT(OFF_LIM)) u_off_cnt (
    .i_clk      (CLK),
    .i_rst_n    (RST_N),
    .i_clr      (r_state != ST_OFF),
    .i_inc      (r_state == ST_OFF),
    .o_count    (w_off_cnt),
    .o_at_limit (w_off_at_lim)
  );

  clk_gate_sat_cnt #(.WIDTH(WAKE_W), .LIMIT(WAKE_LIM)) u_wake_cnt (
    .i_clk      (CLK),
    .i_rst_n    (RST_N),
    .i_clr      (r_state != ST_WAKE),
    .i_inc      (r_state == ST_WAKE),
    .o_count    (w_wake_cnt),
    .o_at_limit (w_wake_at_lim)
  );

  logic w_unused_cnts;
  assign w_unused_cnts = ^{w_idle_cnt, w_off_cnt, w_wake_cnt};

  // NOTE: the next-state default is assigned before the case so no path can infer a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_RUN:  if (w_go_off)      w_next_state = ST_OFF;
      ST_OFF:  if (w_go_wake)     w_next_state = ST_WAKE;
      ST_WAKE: if (w_wake_at_lim) w_next_state = ST_RUN;
      default:                    w_next_state = ST_RUN;
    endcase
  end

  // Outputs are registered from the next state so CE and CLK_ACTIVE move together with STATE.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state      <= ST_RUN;
      r_ce         <= CE_ON;
      r_clk_active <= 1'b1;
      r_wake_pend  <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_ce         <= (w_next_state != ST_OFF) ^ CE_INV;
      r_clk_active <= (w_next_state == ST_RUN);
      r_wake_pend  <= (r_state == ST_OFF) && !w_go_wake &&
                      (r_wake_pend || (w_wanted && !w_off_at_lim));
    end
  end

  assign CE         = r_ce;
  assign CLK_ACTIVE = r_clk_active;
  assign STATE      = r_state;

`ifdef CLK_GATE_CTRL_STATS_EN
  logic w_gated_full, w_wakes_full;

  clk_gate_sat_cnt #(.WIDTH(GATED_CNT_W)) u_gated_cnt (
    .i_clk      (CLK),
    .i_rst_n    (RST_N),
    .i_clr      (1'b0),
    .i_inc      (r_state == ST_OFF),
    .o_count    (GATED_CYCLES),
    .o_at_limit (w_gated_full)
  );

  clk_gate_sat_cnt #(.WIDTH(WAKE_CNT_W)) u_wake_count (
    .i_clk      (CLK),
    .i_rst_n    (RST_N),
    .i_clr      (1'b0),
    .i_inc      (w_go_wake),
    .o_count    (WAKE_COUNT),
    .o_at_limit (w_wakes_full)
  );

  logic w_unused_stats;
  assign w_unused_stats = w_gated_full ^ w_wakes_full;
`endif

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Self-checking bench for clk_gate_ctrl: directed scenarios plus randomized traffic against a behavioural model.
module tb_clk_gate_ctrl;

  localparam int IDLE   = 16;
  localparam int MINOFF = 4;
  localparam int WAKE   = 2;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       BUSY;
  logic       FORCE_ON;
  logic       ce, ce_i, act, act_i;
  logic [1:0] st, st_i;
`ifdef CLK_GATE_CTRL_STATS_EN
  logic [31:0] gated, gated_i;
  logic [15:0] wakes, wakes_i;
`endif

  always #5 CLK = ~CLK;

  clk_gate_ctrl #(.IDLE_CYCLES(IDLE), .MIN_OFF_CYCLES(MINOFF), .WAKE_CYCLES(WAKE),
                  .IS_CE_INVERTED(0)) u_dut (
    .CLK(CLK), .RST_N(RST_N), .BUSY(BUSY), .FORCE_ON(FORCE_ON),
    .CE(ce), .CLK_ACTIVE(act), .STATE(st)
`ifdef CLK_GATE_CTRL_STATS_EN
    , .GATED_CYCLES(gated), .WAKE_COUNT(wakes)
`endif
  );

  clk_gate_ctrl #(.IDLE_CYCLES(IDLE), .MIN_OFF_CYCLES(MINOFF), .WAKE_CYCLES(WAKE),
                  .IS_CE_INVERTED(1)) u_dut_inv (
    .CLK(CLK), .RST_N(RST_N), .BUSY(BUSY), .FORCE_ON(FORCE_ON),
    .CE(ce_i), .CLK_ACTIVE(act_i), .STATE(st_i)
`ifdef CLK_GATE_CTRL_STATS_EN
    , .GATED_CYCLES(gated_i), .WAKE_COUNT(wakes_i)
`endif
  );

  // Behavioural model: clock is either gated, waking (edges left), or running (idle streak).
  bit          m_gated, m_pend;
  int          m_idle, m_off_edges, m_wake_left;
  int unsigned m_gated_cycles, m_wakes;

  int n_vec  = 0;
  int n_fail = 0;

  function automatic logic exp_ce();
    return !m_gated;
  endfunction

  function automatic logic exp_act();
    return !m_gated && (m_wake_left == 0);
  endfunction

  function automatic logic [1:0] exp_state();
    if (m_gated) return 2'b01;
    if (m_wake_left > 0) return 2'b10;
    return 2'b00;
  endfunction

  task automatic model_reset();
    m_gated = 0; m_pend = 0; m_idle = 0; m_off_edges = 0; m_wake_left = 0;
    m_gated_cycles = 0; m_wakes = 0;
  endtask

  task automatic model_step(input logic busy, input logic force_on);
    bit wanted;
    wanted = busy || force_on;
    if (m_wake_left > 0) begin
      m_wake_left--;
    end else if (m_gated) begin
      m_off_edges++;
      m_gated_cycles++;
      if (m_off_edges >= MINOFF && (wanted || m_pend)) begin
        m_gated = 0; m_pend = 0; m_wake_left = WAKE; m_wakes++;
      end else if (wanted) begin
        m_pend = 1;
      end
    end else if (wanted) begin
      m_idle = 0;
    end else begin
      m_idle++;
      if (m_idle == IDLE) begin
        m_gated = 1; m_off_edges = 0; m_idle = 0;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, actual, expected, $time);
    end
  endtask

  task automatic compare_all();
    check("ce",         {31'd0, ce},    {31'd0, exp_ce()});
    check("ce_inv",     {31'd0, ce_i},  {31'd0, !exp_ce()});
    check("clk_active", {31'd0, act},   {31'd0, exp_act()});
    check("clk_act_inv",{31'd0, act_i}, {31'd0, exp_act()});
    check("state",      {30'd0, st},    {30'd0, exp_state()});
    check("state_inv",  {30'd0, st_i},  {30'd0, exp_state()});
`ifdef CLK_GATE_CTRL_STATS_EN
    check("gated_cycles", gated,           m_gated_cycles);
    check("wake_count",   {16'd0, wakes},  m_wakes);
    check("gated_inv",    gated_i,         m_gated_cycles);
    check("wakes_inv",    {16'd0, wakes_i}, m_wakes);
`endif
  endtask

  // Called at a falling edge: drive, let one rising edge pass, then compare at the next falling edge.
  task automatic cycle(input logic busy, input logic force_on);
    BUSY = busy;
    FORCE_ON = force_on;
    @(posedge CLK);
    model_step(busy, force_on);
    @(negedge CLK);
    compare_all();
  endtask

  task automatic apply_reset();
    RST_N = 1'b0;
    BUSY = 1'b0;
    FORCE_ON = 1'b0;
    #1;
    model_reset();
    compare_all();
    check("rst_ce",     {31'd0, ce},   32'd1);
    check("rst_ce_inv", {31'd0, ce_i}, 32'd0);
    check("rst_act",    {31'd0, act},  32'd1);
    check("rst_state",  {30'd0, st},   32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  initial begin
    RST_N = 1'b0;
    BUSY = 1'b0;
    FORCE_ON = 1'b0;
    model_reset();
    @(negedge CLK);
    apply_reset();

    // Gate-off after exactly IDLE idle edges.
    for (int i = 0; i < IDLE - 1; i++) cycle(0, 0);
    check("pre_gate_state", {30'd0, st}, 32'd0);
    cycle(0, 0);
    check("gate_state", {30'd0, st}, 32'd1);
    check("gate_ce",    {31'd0, ce}, 32'd0);
    check("gate_act",   {31'd0, act}, 32'd0);

    // Early wake: pulse during the minimum-off window is remembered.
    cycle(0, 0);
    cycle(1, 0);
    cycle(0, 0);
    check("ew_still_off", {30'd0, st}, 32'd1);
    cycle(0, 0);
    check("ew_wake_state", {30'd0, st}, 32'd2);
    check("ew_wake_ce",    {31'd0, ce}, 32'd1);
    check("ew_wake_act",   {31'd0, act}, 32'd0);
    cycle(0, 0);
    check("ew_act_mid", {31'd0, act}, 32'd0);
    cycle(0, 0);
    check("ew_act_up", {31'd0, act}, 32'd1);
    check("ew_run",    {30'd0, st}, 32'd0);

    // Cancel: wanted on the 15th edge, then wanted on the completing 16th edge.
    for (int i = 0; i < IDLE - 2; i++) cycle(0, 0);
    cycle(1, 0);
    for (int i = 0; i < IDLE - 1; i++) cycle(0, 0);
    check("cancel15_run", {30'd0, st}, 32'd0);
    cycle(0, 1);
    check("cancel16_run", {30'd0, st}, 32'd0);
    for (int i = 0; i < IDLE - 1; i++) cycle(0, 0);
    check("cancel_fresh_run", {30'd0, st}, 32'd0);
    cycle(0, 0);
    check("cancel_fresh_off", {30'd0, st}, 32'd1);

    // FORCE_ON held with BUSY low: from OFF it wakes, then CE never falls.
    for (int i = 0; i < 100; i++) begin
      cycle(0, 1);
      if (i >= MINOFF) check("force_ce", {31'd0, ce}, 32'd1);
    end

    // Reset asserted mid-WAKE takes effect without a clock edge.
    for (int i = 0; i < IDLE; i++) cycle(0, 0);
    for (int i = 0; i < MINOFF; i++) cycle(1, 0);
    check("pre_rst_wake", {30'd0, st}, 32'd2);
    apply_reset();

    // Randomized traffic with occasional asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        apply_reset();
      end else if ((i / 200) % 2 == 0) begin
        cycle($urandom_range(0, 11) == 0, $urandom_range(0, 59) == 0);
      end else begin
        cycle($urandom_range(0, 1) == 0, 1'b0);
      end
    end

`ifdef CLK_GATE_CTRL_STATS_EN
    // Three gate/wake rounds of exactly 10 OFF edges each.
    apply_reset();
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < IDLE; i++) cycle(0, 0);
      for (int i = 0; i < 9; i++) cycle(0, 0);
      cycle(1, 0);
      cycle(1, 0);
      cycle(1, 0);
    end
    check("stats_wakes", {16'd0, wakes}, 32'd3);
    check("stats_gated", gated, 32'd30);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
